decode_execute_register: RTL and testbench
==========================================

// Module: decode_execute_register
// PURPOSE
//  ID/EX pipeline boundary of the vector CPU. Captures the decode-stage control word from controlUnit (*D signals),
//  register operands, destination index and immediate; presents them to execute as *E signals. Owns load-use hazard
//  detection (stalls decode, inserts one bubble), downstream stall hold and branch flush, with a stall counter.
// PARAMETERS
//  SCALAR_WIDTH    32   scalar operand/immediate width
//  VECTOR_WIDTH    128  vector operand width (lanes x element)
//  REG_ADDR_WIDTH  4    register index width (scalar and vector files)
//  COUNT_WIDTH     16   bubble/stall statistics counter width
// PORTS
//  clk                        in   1    single clock, rising edge
//  reset                      in   1    asynchronous, active-low
//  isVectorScalarOperationED / resultSelectorWBD / writeEnableScalarWBD / writeEnableVectorWBD /
//  writeToMemoryEnableMD / useInmediateED / isScalarInstructionED / outFlagMD   in 1 each   control word from decode
//  aluControlED               in   3    ALU op from decode
//  rs1D, rs2D, rdD            in   REG_ADDR_WIDTH  source/destination indices
//  useRs1D, useRs2D           in   1    instruction reads rs1 / rs2
//  rs1VectorD, rs2VectorD     in   1    1 = source read from vector file, 0 = scalar file
//  scalarA/BD                 in   SCALAR_WIDTH   scalar operands;   vectorA/BD  in VECTOR_WIDTH vector operands
//  immD                       in   SCALAR_WIDTH   sign-extended immediate
//  stallE                     in   1    downstream (memory) stall: hold E contents
//  flushE                     in   1    taken branch: kill instruction entering E
//  <each control/operand>E    out  same  registered copy of every *D above except useRs*/rs*Vector
//  validE                     out  1    E holds a real instruction
//  stallD                     out  1    combinational: freeze fetch/decode this cycle
//  bubbleCountE               out  COUNT_WIDTH  saturating count of inserted bubbles
// BEHAVIOUR
//  - Reset (reset=0, async): all *E outputs 0, validE 0, bubbleCountE 0, FSM=RUN. stallD=0 while in reset.
//  - Latency: one cycle D->E when not stalled/flushed.
//  - loadE = validE & resultSelectorWBE & (writeEnableScalarWBE | writeEnableVectorWBE).
//  - hazardD = loadE & ((useRs1D & rs1D==rdE & rs1VectorD==writeEnableVectorWBE) |
//                       (useRs2D & rs2D==rdE & rs2VectorD==writeEnableVectorWBE)).
//  - stallD = (hazardD | stallE) & ~flushE.
//  - Per-edge priority: flushE > stallE > hazardD > normal capture.
//    flushE: load bubble. stallE: hold all E regs unchanged. hazardD: load bubble, FSM RUN->BUBBLE.
//    normal: capture all D fields, validE<=1.
//  - Bubble = validE 0, writeEnableScalarWBE/VectorWBE, writeToMemoryEnableMD, outFlagMD all 0; other fields 0.
//  - FSM: RUN, BUBBLE. BUBBLE lasts exactly one cycle then RUN (E holds a bubble, so loadE=0 and no re-hazard);
//    stallE in BUBBLE keeps BUBBLE; flushE in any state -> RUN.
//  - Opcodes 0000/1111 (NOP): enables arrive 0, captured with validE=1; x-valued non-enable fields captured as-is.
//  - bubbleCountE increments on each hazard bubble (not flush), saturates at all-ones, no wrap.
//  - Reset mid-stall/bubble: immediate return to reset state, no residual stallD.
// STRUCTURE
//  - Shared package cpu_pkg: ctrl_word_t struct (the 9 control fields), opcode localparams, ALU op localparams,
//    default widths. Ports may be grouped as ctrl_word_t internally.
//  - One sub-module: load_use_hazard_detector (combinational hazardD from E/D fields); FSM, register and counter here.
// TESTING
//  1 Reset: reset=0 mid-run with validE=1 -> all E outputs 0, validE 0, bubbleCountE 0 asynchronously.
//  2 Scalar add (0101, rd=3) then vector add (0111, rs1=5): one-cycle pass-through, stallD=0, aluControlE 000 then 000.
//  3 Vector load (0010, rd=2) then vector op reading v2 -> stallD=1 one cycle, one bubble (validE 0), bubbleCountE=1,
//    op enters E next cycle; same rd=2 but scalar-file source (rs1VectorD=0) -> no stall.
//  4 stallE=1 for 3 cycles with store (0001) in E -> E unchanged, stallD=1, then resumes with next instruction.
//  5 flushE=1 coincident with hazardD and stallE -> bubble loaded, stallD=0, bubbleCountE unchanged.
//  6 COUNT_WIDTH=2, force 5 hazards -> bubbleCountE saturates at 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared vector-CPU types: decode control word, opcodes, ALU ops.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int SCALAR_WIDTH_DEF   = 32;
    localparam int VECTOR_WIDTH_DEF   = 128;
    localparam int REG_ADDR_WIDTH_DEF = 4;
    localparam int COUNT_WIDTH_DEF    = 16;

    localparam logic [3:0] OP_NOP_LO = 4'b0000;
    localparam logic [3:0] OP_STORE  = 4'b0001;
    localparam logic [3:0] OP_VLOAD  = 4'b0010;
    localparam logic [3:0] OP_SADD   = 4'b0101;
    localparam logic [3:0] OP_VADD   = 4'b0111;
    localparam logic [3:0] OP_NOP_HI = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef struct packed {
        logic       isVectorScalarOperation;
        logic       resultSelectorWB;
        logic       writeEnableScalarWB;
        logic       writeEnableVectorWB;
        logic       writeToMemoryEnableM;
        logic       useInmediate;
        logic       isScalarInstruction;
        logic       outFlagM;
        logic [2:0] aluControl;
    } ctrl_word_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } pipe_state_t;

endpackage

`default_nettype wire

// File: rtl/load_use_hazard_detector.sv
// ============================================================================
// Module   : load_use_hazard_detector
// Purpose  : Flags a decode instruction reading the register a load in E writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_use_hazard_detector #(
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      i_validE,
    input  logic                      i_resultSelectorWBE,
    input  logic                      i_writeEnableScalarWBE,
    input  logic                      i_writeEnableVectorWBE,
    input  logic [REG_ADDR_WIDTH-1:0] i_rdE,
    input  logic                      i_useRs1D,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1D,
    input  logic                      i_rs1VectorD,
    input  logic                      i_useRs2D,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2D,
    input  logic                      i_rs2VectorD,
    output logic                      o_hazardD
);

    logic w_loadE;
    logic w_match1;
    logic w_match2;

    assign w_loadE = i_validE & i_resultSelectorWBE &
                     (i_writeEnableScalarWBE | i_writeEnableVectorWBE);

    // The register file of the source must match the file the load writes.
    assign w_match1 = i_useRs1D & (i_rs1D == i_rdE) & (i_rs1VectorD == i_writeEnableVectorWBE);
    assign w_match2 = i_useRs2D & (i_rs2D == i_rdE) & (i_rs2VectorD == i_writeEnableVectorWBE);

    assign o_hazardD = w_loadE & (w_match1 | w_match2);

endmodule

`default_nettype wire

// File: rtl/decode_execute_register.sv
// ============================================================================
// Module   : decode_execute_register
// Purpose  : ID/EX pipeline register with load-use bubble, stall hold and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_execute_register
    import cpu_pkg::*;
#(
    parameter int SCALAR_WIDTH   = 32,
    parameter int VECTOR_WIDTH   = 128,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      isVectorScalarOperationED,
    input  logic                      resultSelectorWBD,
    input  logic                      writeEnableScalarWBD,
    input  logic                      writeEnableVectorWBD,
    input  logic                      writeToMemoryEnableMD,
    input  logic                      useInmediateED,
    input  logic                      isScalarInstructionED,
    input  logic                      outFlagMD,
    input  logic [2:0]                aluControlED,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] rdD,
    input  logic                      useRs1D,
    input  logic                      useRs2D,
    input  logic                      rs1VectorD,
    input  logic                      rs2VectorD,
    input  logic [SCALAR_WIDTH-1:0]   scalarAD,
    input  logic [SCALAR_WIDTH-1:0]   scalarBD,
    input  logic [VECTOR_WIDTH-1:0]   vectorAD,
    input  logic [VECTOR_WIDTH-1:0]   vectorBD,
    input  logic [SCALAR_WIDTH-1:0]   immD,
    input  logic                      stallE,
    input  logic                      flushE,
    output logic                      isVectorScalarOperationEE,
    output logic                      resultSelectorWBE,
    output logic                      writeEnableScalarWBE,
    output logic                      writeEnableVectorWBE,
    output logic                      writeToMemoryEnableME,
    output logic                      useInmediateEE,
    output logic                      isScalarInstructionEE,
    output logic                      outFlagME,
    output logic [2:0]                aluControlEE,
    output logic [REG_ADDR_WIDTH-1:0] rdE,
    output logic [SCALAR_WIDTH-1:0]   scalarAE,
    output logic [SCALAR_WIDTH-1:0]   scalarBE,
    output logic [VECTOR_WIDTH-1:0]   vectorAE,
    output logic [VECTOR_WIDTH-1:0]   vectorBE,
    output logic [SCALAR_WIDTH-1:0]   immE,
    output logic                      validE,
    output logic                      stallD,
    output logic [COUNT_WIDTH-1:0]    bubbleCountE
);

    ctrl_word_t                w_ctrlD;
    ctrl_word_t                r_ctrlE;
    logic                      r_validE;
    logic [REG_ADDR_WIDTH-1:0] r_rdE;
    logic [SCALAR_WIDTH-1:0]   r_scalarAE;
    logic [SCALAR_WIDTH-1:0]   r_scalarBE;
    logic [VECTOR_WIDTH-1:0]   r_vectorAE;
    logic [VECTOR_WIDTH-1:0]   r_vectorBE;
    logic [SCALAR_WIDTH-1:0]   r_immE;
    logic [COUNT_WIDTH-1:0]    r_bubbleCount;
    pipe_state_t               r_state;
    pipe_state_t               w_stateNext;
    logic                      w_hazardD;
    logic                      w_loadBubble;
    logic                      w_capture;

    assign w_ctrlD = '{
        isVectorScalarOperation: isVectorScalarOperationED,
        resultSelectorWB:        resultSelectorWBD,
        writeEnableScalarWB:     writeEnableScalarWBD,
        writeEnableVectorWB:     writeEnableVectorWBD,
        writeToMemoryEnableM:    writeToMemoryEnableMD,
        useInmediate:            useInmediateED,
        isScalarInstruction:     isScalarInstructionED,
        outFlagM:                outFlagMD,
        aluControl:              aluControlED
    };

    load_use_hazard_detector #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_hazard (
        .i_validE              (r_validE),
        .i_resultSelectorWBE   (r_ctrlE.resultSelectorWB),
        .i_writeEnableScalarWBE(r_ctrlE.writeEnableScalarWB),
        .i_writeEnableVectorWBE(r_ctrlE.writeEnableVectorWB),
        .i_rdE                 (r_rdE),
        .i_useRs1D             (useRs1D),
        .i_rs1D                (rs1D),
        .i_rs1VectorD          (rs1VectorD),
        .i_useRs2D             (useRs2D),
        .i_rs2D                (rs2D),
        .i_rs2VectorD          (rs2VectorD),
        .o_hazardD             (w_hazardD)
    );

    // Gating with reset keeps an external stallE from freezing decode during reset.
    assign stallD       = reset & ~flushE & (w_hazardD | stallE);
    assign w_loadBubble = flushE | (~stallE & w_hazardD);
    assign w_capture    = ~flushE & ~stallE & ~w_hazardD;

    always_comb begin
        w_stateNext = r_state;
        if (flushE)
            w_stateNext = ST_RUN;
        else if (!stallE)
            w_stateNext = w_hazardD ? ST_BUBBLE : ST_RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_validE      <= 1'b0;
            r_ctrlE       <= '0;
            r_rdE         <= '0;
            r_scalarAE    <= '0;
            r_scalarBE    <= '0;
            r_vectorAE    <= '0;
            r_vectorBE    <= '0;
            r_immE        <= '0;
            r_bubbleCount <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_loadBubble) begin
                r_validE   <= 1'b0;
                r_ctrlE    <= '0;
                r_rdE      <= '0;
                r_scalarAE <= '0;
                r_scalarBE <= '0;
                r_vectorAE <= '0;
                r_vectorBE <= '0;
                r_immE     <= '0;
            end else if (w_capture) begin
                r_validE   <= 1'b1;
                r_ctrlE    <= w_ctrlD;
                r_rdE      <= rdD;
                r_scalarAE <= scalarAD;
                r_scalarBE <= scalarBD;
                r_vectorAE <= vectorAD;
                r_vectorBE <= vectorBD;
                r_immE     <= immD;
            end
            // Only load-use bubbles are counted; flush bubbles are not.
            if (!flushE && !stallE && w_hazardD && (r_bubbleCount != '1))
                r_bubbleCount <= r_bubbleCount + 1'b1;
        end
    end

    assign isVectorScalarOperationEE = r_ctrlE.isVectorScalarOperation;
    assign resultSelectorWBE         = r_ctrlE.resultSelectorWB;
    assign writeEnableScalarWBE      = r_ctrlE.writeEnableScalarWB;
    assign writeEnableVectorWBE      = r_ctrlE.writeEnableVectorWB;
    assign writeToMemoryEnableME     = r_ctrlE.writeToMemoryEnableM;
    assign useInmediateEE            = r_ctrlE.useInmediate;
    assign isScalarInstructionEE     = r_ctrlE.isScalarInstruction;
    assign outFlagME                 = r_ctrlE.outFlagM;
    assign aluControlEE              = r_ctrlE.aluControl;
    assign rdE                       = r_rdE;
    assign scalarAE                  = r_scalarAE;
    assign scalarBE                  = r_scalarBE;
    assign vectorAE                  = r_vectorAE;
    assign vectorBE                  = r_vectorBE;
    assign immE                      = r_immE;
    assign validE                    = r_validE;
    assign bubbleCountE              = r_bubbleCount;

endmodule

`default_nettype wire

// File: tb/tb_decode_execute_register.sv
// ============================================================================
// Module   : tb_decode_execute_register
// Purpose  : Directed + randomized check of the ID/EX register against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_execute_register;

    localparam int SW = 32;
    localparam int VW = 128;
    localparam int AW = 4;
    localparam int CW = 2;
    localparam int BUBBLE_MAX = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    // Control word bit order: isVS, resSel, weS, weV, wrMem, useImm, isScalar, outFlag, alu[2:0]
    logic [10:0]   dCtrl = '0;
    logic [AW-1:0] rs1D = '0, rs2D = '0, rdD = '0;
    logic          useRs1D = 1'b0, useRs2D = 1'b0, rs1VectorD = 1'b0, rs2VectorD = 1'b0;
    logic [SW-1:0] scalarAD = '0, scalarBD = '0, immD = '0;
    logic [VW-1:0] vectorAD = '0, vectorBD = '0;
    logic          stallE = 1'b0, flushE = 1'b0;

    logic          oIsVS, oResSel, oWeS, oWeV, oWrMem, oUseImm, oIsScalar, oOutFlag;
    logic [2:0]    oAlu;
    logic [AW-1:0] rdE;
    logic [SW-1:0] scalarAE, scalarBE, immE;
    logic [VW-1:0] vectorAE, vectorBE;
    logic          validE, stallD;
    logic [CW-1:0] bubbleCountE;

    int passed = 0;
    int total  = 0;

    // Reference state of the E stage
    logic          mValid = 1'b0;
    logic [10:0]   mCtrl  = '0;
    logic [355:0]  mData  = '0;
    int            mBubbles = 0;

    wire [10:0]  obsCtrl  = {oIsVS, oResSel, oWeS, oWeV, oWrMem, oUseImm, oIsScalar, oOutFlag, oAlu};
    wire [355:0] obsData  = {rdE, scalarAE, scalarBE, immE, vectorAE, vectorBE};
    wire [355:0] dData    = {rdD, scalarAD, scalarBD, immD, vectorAD, vectorBD};

    decode_execute_register #(
        .SCALAR_WIDTH(SW), .VECTOR_WIDTH(VW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .isVectorScalarOperationED(dCtrl[10]),
        .resultSelectorWBD        (dCtrl[9]),
        .writeEnableScalarWBD     (dCtrl[8]),
        .writeEnableVectorWBD     (dCtrl[7]),
        .writeToMemoryEnableMD    (dCtrl[6]),
        .useInmediateED           (dCtrl[5]),
        .isScalarInstructionED    (dCtrl[4]),
        .outFlagMD                (dCtrl[3]),
        .aluControlED             (dCtrl[2:0]),
        .rs1D                     (rs1D),
        .rs2D                     (rs2D),
        .rdD                      (rdD),
        .useRs1D                  (useRs1D),
        .useRs2D                  (useRs2D),
        .rs1VectorD               (rs1VectorD),
        .rs2VectorD               (rs2VectorD),
        .scalarAD                 (scalarAD),
        .scalarBD                 (scalarBD),
        .vectorAD                 (vectorAD),
        .vectorBD                 (vectorBD),
        .immD                     (immD),
        .stallE                   (stallE),
        .flushE                   (flushE),
        .isVectorScalarOperationEE(oIsVS),
        .resultSelectorWBE        (oResSel),
        .writeEnableScalarWBE     (oWeS),
        .writeEnableVectorWBE     (oWeV),
        .writeToMemoryEnableME    (oWrMem),
        .useInmediateEE           (oUseImm),
        .isScalarInstructionEE    (oIsScalar),
        .outFlagME                (oOutFlag),
        .aluControlEE             (oAlu),
        .rdE                      (rdE),
        .scalarAE                 (scalarAE),
        .scalarBE                 (scalarBE),
        .vectorAE                 (vectorAE),
        .vectorBE                 (vectorBE),
        .immE                     (immE),
        .validE                   (validE),
        .stallD                   (stallD),
        .bubbleCountE             (bubbleCountE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else
            passed++;
    endtask

    task automatic modelReset();
        mValid   = 1'b0;
        mCtrl    = '0;
        mData    = '0;
        mBubbles = 0;
    endtask

    // Called just after a falling edge with D inputs already applied.
    task automatic step(input string tag);
        logic loadE, hz, expStall;
        logic [AW-1:0] eRd;
        #1;
        eRd      = mData[355:352];
        loadE    = mValid && mCtrl[9] && (mCtrl[8] || mCtrl[7]);
        hz       = loadE && ((useRs1D && rs1D == eRd && rs1VectorD == mCtrl[7]) ||
                             (useRs2D && rs2D == eRd && rs2VectorD == mCtrl[7]));
        expStall = (hz || stallE) && !flushE;
        chk({tag, ".stallD"}, {511'b0, stallD}, {511'b0, expStall});
        if (flushE) begin
            mValid = 1'b0; mCtrl = '0; mData = '0;
        end else if (!stallE) begin
            if (hz) begin
                mValid = 1'b0; mCtrl = '0; mData = '0;
                if (mBubbles < BUBBLE_MAX) mBubbles++;
            end else begin
                mValid = 1'b1; mCtrl = dCtrl; mData = dData;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".validE"}, {511'b0, validE}, {511'b0, mValid});
        chk({tag, ".ctrl"}, {501'b0, obsCtrl}, {501'b0, mCtrl});
        chk({tag, ".data"}, {156'b0, obsData}, {156'b0, mData});
        chk({tag, ".bubbles"}, {510'b0, bubbleCountE}, 512'(mBubbles));
    endtask

    task automatic setInstr(input logic [10:0] ctrl, input int rd, input int rs1, input logic u1,
                            input logic v1, input int rs2, input logic u2, input logic v2);
        dCtrl = ctrl; rdD = AW'(rd);
        rs1D = AW'(rs1); useRs1D = u1; rs1VectorD = v1;
        rs2D = AW'(rs2); useRs2D = u2; rs2VectorD = v2;
        scalarAD = $urandom; scalarBD = $urandom; immD = $urandom;
        vectorAD = {$urandom, $urandom, $urandom, $urandom};
        vectorBD = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic randInstr();
        setInstr(11'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        if ($urandom_range(0, 2) == 0) dCtrl[9] = 1'b1;
    endtask

    // Control words: vector load, vector op, scalar op, store
    localparam logic [10:0] C_VLOAD = 11'b010_1000_0000;
    localparam logic [10:0] C_VADD  = 11'b000_1000_0000;
    localparam logic [10:0] C_SADD  = 11'b001_0000_1000;
    localparam logic [10:0] C_STORE = 11'b000_0101_1000;

    initial begin
        // Reset held with stallE asserted: decode must not be stalled
        stallE = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.stallD", {511'b0, stallD}, 512'd0);
        chk("rst.validE", {511'b0, validE}, 512'd0);
        chk("rst.bubbles", {510'b0, bubbleCountE}, 512'd0);
        stallE = 1'b0;
        reset  = 1'b1;
        modelReset();

        // Scalar add then vector add: straight pass-through
        setInstr(C_SADD, 3, 1, 1'b1, 1'b0, 2, 1'b1, 1'b0); step("sadd");
        setInstr(C_VADD, 6, 5, 1'b1, 1'b1, 4, 1'b0, 1'b1); step("vadd");

        // Vector load v2 then consumer of v2: one bubble, then the consumer enters
        setInstr(C_VLOAD, 2, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); step("vload");
        setInstr(C_VADD, 7, 2, 1'b1, 1'b1, 1, 1'b0, 1'b1); step("luse");
        step("luse2");
        // Same index but scalar-file source: no hazard
        setInstr(C_VLOAD, 2, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); step("vload2");
        setInstr(C_SADD, 8, 2, 1'b1, 1'b0, 3, 1'b0, 1'b0); step("noHz");

        // Store held by downstream stall for three cycles
        setInstr(C_STORE, 0, 4, 1'b1, 1'b0, 5, 1'b1, 1'b0); step("store");
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin randInstr(); step("hold"); end
        stallE = 1'b0;
        setInstr(C_SADD, 9, 1, 1'b1, 1'b0, 1, 1'b0, 1'b0); step("resume");

        // Flush wins over stall and hazard, bubble count unchanged
        setInstr(C_VLOAD, 5, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); step("vload3");
        setInstr(C_VADD, 1, 5, 1'b1, 1'b1, 5, 1'b1, 1'b1);
        stallE = 1'b1; flushE = 1'b1; step("flush");
        stallE = 1'b0; flushE = 1'b0;

        // Five hazards against a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            setInstr(C_VLOAD, 6, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); step("satLd");
            setInstr(C_VADD, 2, 0, 1'b0, 1'b1, 6, 1'b1, 1'b1); step("satHz");
            step("satGo");
        end

        // Asynchronous reset mid-run with a valid instruction in E
        setInstr(C_SADD, 4, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0); step("preRst");
        #2 reset = 1'b0; stallE = 1'b1;
        #1;
        chk("arst.validE", {511'b0, validE}, 512'd0);
        chk("arst.ctrl", {501'b0, obsCtrl}, 512'd0);
        chk("arst.data", {156'b0, obsData}, 512'd0);
        chk("arst.bubbles", {510'b0, bubbleCountE}, 512'd0);
        chk("arst.stallD", {511'b0, stallD}, 512'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1; stallE = 1'b0;

        // Randomized traffic with occasional stalls and flushes
        for (int n = 0; n < 300; n++) begin
            randInstr();
            stallE = ($urandom_range(0, 6) == 0);
            flushE = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
